// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths, reset address, fetch FSM encoding, opcodes
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int              ADDR_WIDTH_DEF  = 8;
  localparam int              INSTR_WIDTH_DEF = 6;
  localparam logic [7:0]      RESET_ADDR_DEF  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_t;

  // Opcode field is the upper two bits of the instruction word
  localparam logic [1:0] OPC_ALU    = 2'b00;
  localparam logic [1:0] OPC_LOAD   = 2'b01;
  localparam logic [1:0] OPC_STORE  = 2'b10;
  localparam logic [1:0] OPC_BRANCH = 2'b11;

  function automatic logic [1:0] opcode_of(input logic [INSTR_WIDTH_DEF-1:0] instr);
    return instr[INSTR_WIDTH_DEF-1 -: 2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_pc.sv
// ============================================================================
// program_counter : loadable, incrementing PC that wraps modulo 2^ADDR_WIDTH
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_counter #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_next
);

  // Load has priority; increment wraps naturally at the register width
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = load_addr;
    end else if (inc) begin
      pc_next = pc + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_ADDR;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : PC owner, memory read handshake, instruction register
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int                    INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = ADDR_WIDTH'(RESET_ADDR_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ready,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  input  logic                   instr_accept,
  input  logic                   jump_en,
  input  logic [ADDR_WIDTH-1:0]  jump_addr,
  output logic [ADDR_WIDTH-1:0]  pc
);

  fetch_state_t          state, state_next;
  logic                  pc_load;
  logic                  pc_inc;
  logic                  capture;
  logic                  start_fetch;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [INSTR_WIDTH-1:0] instr_reg;

  program_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (jump_addr),
    .pc        (pc),
    .pc_next   (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A jump that lands on the same edge as a fetch start must be fetched,
  // so every start latches the post-edge PC value rather than the current one.
  always_comb begin
    state_next  = state;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    capture     = 1'b0;
    start_fetch = 1'b0;
    case (state)
      ST_IDLE: begin
        pc_load = jump_en;
        if (run) begin
          state_next  = ST_FETCH;
          start_fetch = 1'b1;
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          if (jump_en) begin
            pc_load     = 1'b1;
            start_fetch = run;
            state_next  = run ? ST_FETCH : ST_IDLE;
          end else begin
            capture    = 1'b1;
            pc_inc     = 1'b1;
            state_next = ST_FULL;
          end
        end else if (jump_en) begin
          pc_load    = 1'b1;
          state_next = ST_FLUSH;
        end
      end
      ST_FULL: begin
        if (instr_accept || jump_en) begin
          pc_load     = jump_en;
          start_fetch = run;
          state_next  = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        pc_load = jump_en;
        if (mem_ready) begin
          start_fetch = run;
          state_next  = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr <= RESET_ADDR;
      instr_reg  <= '0;
    end else begin
      if (start_fetch) begin
        fetch_addr <= pc_next;
      end
      if (capture) begin
        instr_reg <= mem_data;
      end
    end
  end

  assign mem_req     = (state == ST_FETCH) || (state == ST_FLUSH);
  assign instr_valid = (state == ST_FULL);
  assign mem_addr    = fetch_addr;
  assign instruction = instr_reg;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch : directed vector table plus randomized model checks
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready = 1'b0;
  logic [5:0] mem_data = '0;
  logic [5:0] instruction;
  logic       instr_valid;
  logic       instr_accept = 1'b0;
  logic       jump_en = 1'b0;
  logic [7:0] jump_addr = '0;
  logic [7:0] pc;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_data     (mem_data),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: a request is either outstanding or not,
  // and an outstanding one may have been orphaned by a jump.
  logic       m_req, m_stale, m_valid;
  logic [7:0] m_pc, m_addr;
  logic [5:0] m_word;

  task automatic model_reset();
    m_req = 0; m_stale = 0; m_valid = 0;
    m_pc = 8'h00; m_addr = 8'h00; m_word = 6'h00;
  endtask

  task automatic model_edge();
    logic       start;
    logic [7:0] npc;
    start = 0;
    npc   = m_pc;
    if (m_req) begin
      if (mem_ready) begin
        m_req = 0;
        if (!m_stale && !jump_en) begin
          m_word  = mem_data;
          m_valid = 1;
          npc     = m_pc + 8'd1;
        end else begin
          m_stale = 0;
          start   = run;
          if (jump_en) npc = jump_addr;
        end
      end else if (jump_en) begin
        m_stale = 1;
        npc     = jump_addr;
      end
    end else if (m_valid) begin
      if (instr_accept || jump_en) begin
        m_valid = 0;
        start   = run;
        if (jump_en) npc = jump_addr;
      end
    end else begin
      if (jump_en) npc = jump_addr;
      start = run;
    end
    m_pc = npc;
    if (start) begin
      m_req  = 1;
      m_addr = npc;
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic [5:0] d,
                      input logic acc, input logic j, input logic [7:0] ja);
    run = r; mem_ready = rdy; mem_data = d;
    instr_accept = acc; jump_en = j; jump_addr = ja;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got req/addr/valid/instr/pc=%h required %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pack_out(input logic rq, input logic [7:0] a, input logic v,
                                           input logic [5:0] i, input logic [7:0] p);
    return {rq, a, v, i, p};
  endfunction

  typedef struct {
    logic       run, ready;
    logic [5:0] data;
    logic       accept, jump;
    logic [7:0] jaddr;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [5:0] e_instr;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[21];

  initial begin
    //          run rdy data   acc jmp jaddr  | req addr  vld instr  pc
    vecs[0]  = '{1, 0, 6'h00, 1, 0, 8'h00, 1, 8'h00, 0, 6'h00, 8'h00};
    vecs[1]  = '{1, 1, 6'h05, 1, 0, 8'h00, 0, 8'h00, 1, 6'h05, 8'h01};
    vecs[2]  = '{1, 0, 6'h00, 1, 0, 8'h00, 1, 8'h01, 0, 6'h05, 8'h01};
    vecs[3]  = '{1, 1, 6'h1C, 1, 0, 8'h00, 0, 8'h01, 1, 6'h1C, 8'h02};
    vecs[4]  = '{1, 0, 6'h00, 1, 0, 8'h00, 1, 8'h02, 0, 6'h1C, 8'h02};
    vecs[5]  = '{1, 0, 6'h00, 1, 1, 8'h40, 1, 8'h02, 0, 6'h1C, 8'h40};
    vecs[6]  = '{1, 1, 6'h3F, 1, 0, 8'h00, 1, 8'h40, 0, 6'h1C, 8'h40};
    vecs[7]  = '{0, 0, 6'h00, 0, 0, 8'h00, 1, 8'h40, 0, 6'h1C, 8'h40};
    vecs[8]  = '{0, 1, 6'h2A, 0, 0, 8'h00, 0, 8'h40, 1, 6'h2A, 8'h41};
    vecs[9]  = '{1, 0, 6'h00, 0, 0, 8'h00, 0, 8'h40, 1, 6'h2A, 8'h41};
    vecs[10] = '{0, 0, 6'h00, 1, 0, 8'h00, 0, 8'h40, 0, 6'h2A, 8'h41};
    vecs[11] = '{0, 0, 6'h00, 0, 1, 8'hFF, 0, 8'h40, 0, 6'h2A, 8'hFF};
    vecs[12] = '{1, 0, 6'h00, 0, 0, 8'h00, 1, 8'hFF, 0, 6'h2A, 8'hFF};
    vecs[13] = '{1, 1, 6'h11, 0, 0, 8'h00, 0, 8'hFF, 1, 6'h11, 8'h00};
    vecs[14] = '{1, 0, 6'h00, 1, 0, 8'h00, 1, 8'h00, 0, 6'h11, 8'h00};
    vecs[15] = '{1, 0, 6'h00, 0, 0, 8'h00, 1, 8'h00, 0, 6'h11, 8'h00};
    vecs[16] = '{1, 0, 6'h00, 0, 0, 8'h00, 1, 8'h00, 0, 6'h11, 8'h00};
    vecs[17] = '{1, 0, 6'h00, 0, 0, 8'h00, 1, 8'h00, 0, 6'h11, 8'h00};
    vecs[18] = '{1, 1, 6'h07, 0, 0, 8'h00, 0, 8'h00, 1, 6'h07, 8'h01};
    vecs[19] = '{1, 0, 6'h00, 0, 1, 8'h03, 1, 8'h03, 0, 6'h07, 8'h03};
    vecs[20] = '{1, 1, 6'h15, 0, 1, 8'h80, 1, 8'h80, 0, 6'h07, 8'h80};

    model_reset();
    #12;
    check("reset_state", pack_out(mem_req, mem_addr, instr_valid, instruction, pc),
          pack_out(0, 8'h00, 0, 6'h00, 8'h00));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].run, vecs[i].ready, vecs[i].data, vecs[i].accept, vecs[i].jump, vecs[i].jaddr);
      check($sformatf("vec%0d", i), pack_out(mem_req, mem_addr, instr_valid, instruction, pc),
            pack_out(vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc));
    end

    // Reset asserted mid-FLUSH must drop the handshake without waiting for a clock
    step(1, 0, 6'h00, 0, 1, 8'h22);
    check("enter_flush", pack_out(mem_req, mem_addr, instr_valid, instruction, pc),
          pack_out(1, 8'h80, 0, 6'h07, 8'h22));
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", pack_out(mem_req, mem_addr, instr_valid, instruction, pc),
          pack_out(0, 8'h00, 0, 6'h00, 8'h00));
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 6'h00, 0, 0, 8'h00);
    check("fetch_after_reset", pack_out(mem_req, mem_addr, instr_valid, instruction, pc),
          pack_out(1, 8'h00, 0, 6'h00, 8'h00));

    for (int n = 0; n < 3000; n++) begin
      logic       r, rdy, acc, j;
      logic [5:0] d;
      logic [7:0] ja;
      r   = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      d   = 6'($urandom);
      acc = ($urandom_range(0, 1) == 1);
      j   = ($urandom_range(0, 11) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step(r, rdy, d, acc, j, ja);
      check($sformatf("rand%0d", n), pack_out(mem_req, mem_addr, instr_valid, instruction, pc),
            pack_out(m_req, m_addr, m_valid, m_word, m_pc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
